// File: rtl/core_seq_if.sv
// rtl/core_seq_if.sv - job control, source load and drain handshake bundle for core_seq
// master = sequencer side, slave = job requester / data source / core side.
interface core_seq_if;
  logic        start;
  logic [4:0]  q_len;
  logic        in_valid;
  logic        in_ready;
  logic        fifo_valid;
  logic [16:0] inst;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  start, q_len, in_valid, fifo_valid,
    output in_ready, inst, busy, done, err
  );

  modport slave (
    output start, q_len, in_valid, fifo_valid,
    input  in_ready, inst, busy, done, err
  );
endinterface

// File: rtl/core_seq.sv
// rtl/core_seq.sv - attention-core instruction sequencer (load Q/K, kernel load, execute, drain)
// Optional drain watchdog: define CORE_SEQ_TIMEOUT_EN.
module core_seq #(
  parameter int col    = 8,
  parameter int pr     = 16,
  parameter int addr_w = 4
) (
  input logic        clk,
  input logic        reset,
  core_seq_if.master bus
);

  typedef enum logic [2:0] {IDLE, QWR, KWR, KLD, EXE, DRN, FIN} state_t;

  localparam logic [4:0] col_last = 5'(col - 1);
  localparam logic [4:0] col_n    = 5'(col);
  localparam logic [4:0] q_max    = 5'(1 << addr_w);

  state_t     state;
  logic [4:0] cnt;
  logic [4:0] q_len_r;
  logic       start_ok;

  assign start_ok = bus.start && (bus.q_len != 5'd0) && (bus.q_len <= q_max);

`ifdef CORE_SEQ_TIMEOUT_EN
  logic [7:0] wd;
  logic       err_r;
  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      q_len_r <= 5'd0;
`ifdef CORE_SEQ_TIMEOUT_EN
      wd      <= 8'd0;
      err_r   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            state   <= QWR;
            cnt     <= 5'd0;
            q_len_r <= bus.q_len;
`ifdef CORE_SEQ_TIMEOUT_EN
            err_r   <= 1'b0;
`endif
          end
        end
        QWR: begin
          if (bus.in_valid) begin
            if (cnt == q_len_r - 5'd1) begin
              state <= KWR;
              cnt   <= 5'd0;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        KWR: begin
          if (bus.in_valid) begin
            if (cnt == col_last) begin
              state <= KLD;
              cnt   <= 5'd0;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        // One extra cycle after the last read covers the K SRAM read latency.
        KLD: begin
          if (cnt == col_n) begin
            state <= EXE;
            cnt   <= 5'd0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        EXE: begin
          if (cnt == q_len_r) begin
            state <= DRN;
            cnt   <= 5'd0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        DRN: begin
          if (bus.fifo_valid) begin
`ifdef CORE_SEQ_TIMEOUT_EN
            wd <= 8'd0;
`endif
            if (cnt == q_len_r - 5'd1) begin
              state <= FIN;
              cnt   <= 5'd0;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
`ifdef CORE_SEQ_TIMEOUT_EN
          // 255th consecutive idle drain cycle abandons the job.
          else if (wd == 8'd254) begin
            state <= IDLE;
            cnt   <= 5'd0;
            wd    <= 8'd0;
            err_r <= 1'b1;
          end else begin
            wd <= wd + 8'd1;
          end
`endif
        end
        FIN: begin
          state <= IDLE;
          cnt   <= 5'd0;
        end
        default: begin
          state <= IDLE;
          cnt   <= 5'd0;
        end
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == FIN);

  always_comb begin
    bus.inst     = 17'd0;
    bus.in_ready = 1'b0;
    case (state)
      QWR: begin
        bus.in_ready     = 1'b1;
        bus.inst[15:12]  = cnt[3:0];
        bus.inst[4]      = bus.in_valid;
      end
      KWR: begin
        bus.in_ready     = 1'b1;
        bus.inst[15:12]  = cnt[3:0];
        bus.inst[2]      = bus.in_valid;
      end
      KLD: begin
        bus.inst[15:12]  = cnt[3:0];
        bus.inst[6]      = 1'b1;
        bus.inst[3]      = (cnt < col_n);
      end
      EXE: begin
        bus.inst[15:12]  = cnt[3:0];
        bus.inst[7]      = 1'b1;
        bus.inst[5]      = (cnt < q_len_r);
      end
      DRN: begin
        bus.inst[11:8]   = cnt[3:0];
        bus.inst[16]     = bus.fifo_valid;
        bus.inst[0]      = bus.fifo_valid;
      end
      default: begin
        bus.inst     = 17'd0;
        bus.in_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_core_seq.sv
// tb/tb_core_seq.sv - directed self-checking bench for core_seq
// Build with CORE_SEQ_TIMEOUT_EN defined to also exercise the drain watchdog.
module tb_core_seq;
  localparam int col = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  core_seq_if bus();

  core_seq #(.col(col), .pr(16), .addr_w(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [16:0] tr[$];
  logic        rdy[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode 0: all valid high; 1: in_valid gaps in QWR; 2: drain stall; 3: q16 with stray starts
  task automatic run_job(input int ql, input int mode, output int done_cyc);
    tr.delete();
    rdy.delete();
    done_cyc = -1;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.q_len      = 5'(ql);
    bus.in_valid   = 1'b1;
    bus.fifo_valid = 1'b1;
    #1 check("idle_busy", {31'd0, bus.busy}, 0);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      bus.start      = (mode == 3) && (c == 10 || c == 67);
      bus.q_len      = bus.start ? 5'd3 : 5'(ql);
      bus.in_valid   = !(mode == 1 && (c == 2 || c == 3));
      bus.fifo_valid = !(mode == 2 && c >= 28 && c <= 37);
      #1;
      tr.push_back(bus.inst);
      rdy.push_back(bus.in_ready);
      if (c == 1) check("busy_t1", {31'd0, bus.busy}, 1);
      if (bus.done) begin
        done_cyc = c;
        break;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check("done_pulse", {31'd0, bus.done}, 0);
    check("idle_after", {31'd0, bus.busy}, 0);
  endtask

  task automatic chk_strobe(input string tag, input int b, input bit pm, input int exp_n);
    int n;
    n = 0;
    foreach (tr[i]) begin
      if (tr[i][b]) begin
        check({tag, "_add"}, pm ? {28'd0, tr[i][11:8]} : {28'd0, tr[i][15:12]}, n);
        n++;
      end
    end
    check({tag, "_n"}, n, exp_n);
  endtask

  task automatic check_trace(input int ql, input int exp_done, input int exp_rdy, input int done_cyc);
    int n6, n7, nr, nbad;
    n6 = 0; n7 = 0; nr = 0; nbad = 0;
    check("done_cyc", done_cyc, exp_done);
    chk_strobe("qmem_wr", 4, 1'b0, ql);
    chk_strobe("kmem_wr", 2, 1'b0, col);
    chk_strobe("kmem_rd", 3, 1'b0, col);
    chk_strobe("qmem_rd", 5, 1'b0, ql);
    chk_strobe("pmem_wr", 0, 1'b1, ql);
    foreach (tr[i]) begin
      if (tr[i][6]) n6++;
      if (tr[i][7]) n7++;
      if (tr[i][16] != tr[i][0] || tr[i][1]) nbad++;
    end
    foreach (rdy[i]) if (rdy[i]) nr++;
    check("kload_cycles", n6, col + 1);
    check("exec_cycles", n7, ql + 1);
    check("ofifo_pmem", nbad, 0);
    check("in_ready_cycles", nr, exp_rdy);
  endtask

  int dc;
  int nstall;
  bit seen_done;

  initial begin
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.q_len      = 5'd0;
    bus.in_valid   = 1'b0;
    bus.fifo_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_inst", {15'd0, bus.inst}, 0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 0);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_done", {31'd0, bus.done}, 0);
    check("rst_err", {31'd0, bus.err}, 0);
    @(negedge clk);
    reset = 1'b1;

    run_job(4, 0, dc);
    check_trace(4, 31, 12, dc);

    // q_len outside 1..16 must not start a job
    @(negedge clk); bus.start = 1'b1; bus.q_len = 5'd0;
    @(negedge clk); bus.start = 1'b0;
    #1 check("qlen0_busy", {31'd0, bus.busy}, 0);
    @(negedge clk); bus.start = 1'b1; bus.q_len = 5'd17;
    @(negedge clk); bus.start = 1'b0;
    #1 check("qlen17_busy", {31'd0, bus.busy}, 0);

    run_job(2, 1, dc);
    check_trace(2, 27, 12, dc);

    run_job(4, 2, dc);
    check_trace(4, 41, 12, dc);
    nstall = 0;
    for (int i = 27; i <= 36; i++)
      if (tr[i][11:8] == 4'd1 && !tr[i][0] && !tr[i][16]) nstall++;
    check("stall_hold", nstall, 10);

    run_job(16, 3, dc);
    check_trace(16, 67, 24, dc);

    // Asynchronous reset in the middle of EXE
    @(negedge clk);
    bus.start = 1'b1; bus.q_len = 5'd16; bus.in_valid = 1'b1; bus.fifo_valid = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #1 check("exe_before_rst", {31'd0, bus.inst[7]}, 1);
    #1 reset = 1'b0;
    #1;
    check("arst_inst", {15'd0, bus.inst}, 0);
    check("arst_busy", {31'd0, bus.busy}, 0);
    check("arst_in_ready", {31'd0, bus.in_ready}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_job(4, 0, dc);
    check_trace(4, 31, 12, dc);

`ifdef CORE_SEQ_TIMEOUT_EN
    @(negedge clk);
    bus.start = 1'b1; bus.q_len = 5'd1; bus.in_valid = 1'b1; bus.fifo_valid = 1'b1;
    seen_done = 1'b0;
    for (int c = 1; c <= 276; c++) begin
      @(negedge clk);
      bus.start      = 1'b0;
      bus.fifo_valid = (c < 21);
      #1;
      if (bus.done) seen_done = 1'b1;
      if (c == 275) check("to_busy_275", {31'd0, bus.busy}, 1);
    end
    check("to_err", {31'd0, bus.err}, 1);
    check("to_busy", {31'd0, bus.busy}, 0);
    check("to_inst", {15'd0, bus.inst}, 0);
    check("to_no_done", {31'd0, seen_done}, 0);
    @(negedge clk); bus.start = 1'b1; bus.q_len = 5'd1; bus.fifo_valid = 1'b1;
    #1 check("err_sticky", {31'd0, bus.err}, 1);
    @(negedge clk); bus.start = 1'b0;
    #1 check("err_clear", {31'd0, bus.err}, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
